// File: rtl/pulse_receiver_duration_capture_if.sv
// Read port of the pulse duration capture FIFO: head entry with valid/ready pop handshake.
interface pulse_receiver_duration_capture_if #(
   parameter int DATA_W = 10
);
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;

   modport master (output out_data, output out_valid, input out_ready);
   modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/pulse_receiver_duration_capture.sv
// Measures the spacing of edges on sig_in in prescaled ticks and queues {idle, level, duration}
// entries in a small FIFO. A silent line is closed by a timeout entry.
//
// state     | meaning
// ----------|--------------------------------------------------------------
// S_IDLE    | waiting for the first edge; nothing is pushed
// S_MEASURE | timing the current segment; push on edge or on timeout
module pulse_receiver_duration_capture #(
   parameter int PRESCALER_WIDTH = 16,
   parameter int TIMER_WIDTH     = 8,
   parameter int FIFO_DEPTH      = 4,
   localparam int PSEL_WIDTH     = $clog2(PRESCALER_WIDTH + 1),
   localparam int ENTRY_WIDTH    = TIMER_WIDTH + 2
) (
   input  logic                   clk,
   input  logic                   sys_rst,
   input  logic                   en,
   input  logic [PSEL_WIDTH-1:0]  prescaler,
   input  logic                   sig_in,
   output logic                   overflow,
   input  logic                   clr_overflow,
   output logic                   busy,
   pulse_receiver_duration_capture_if.master rd
);
   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic {S_IDLE = 1'b0, S_MEASURE = 1'b1} state_t;

   state_t                    state, state_nxt;
   logic                      sync1, sync2, edge_reg, edge_det;
   logic [PRESCALER_WIDTH-1:0] pcnt, pmask;
   logic [TIMER_WIDTH:0]      tcnt;
   logic [TIMER_WIDTH-1:0]    duration;
   logic                      restart, push_req;
   logic [ENTRY_WIDTH-1:0]    push_entry;
   logic                      push_vld;
   logic [ENTRY_WIDTH-1:0]    push_dat;
   logic [ENTRY_WIDTH-1:0]    mem [FIFO_DEPTH];
   logic [AW-1:0]             wr_ptr, rd_ptr;
   logic [AW:0]               count;
   logic [ENTRY_WIDTH-1:0]    last_q;
   logic                      pop, accept;

   always_ff @(posedge clk or posedge sys_rst) begin
      if (sys_rst) begin
         sync1    <= 1'b0;
         sync2    <= 1'b0;
         edge_reg <= 1'b0;
      end else begin
         sync1    <= sig_in;
         sync2    <= sync1;
         edge_reg <= sync2;
      end
   end

   assign edge_det = sync2 ^ edge_reg;
   assign pmask    = ~({PRESCALER_WIDTH{1'b1}} << prescaler);
   // tcnt holds (C-1)>>p at the closing edge, so the reported value is one less, floored at zero
   assign duration = (tcnt == '0) ? '0 : TIMER_WIDTH'(tcnt - 1'b1);

   always_ff @(posedge clk or posedge sys_rst) begin
      if (sys_rst) state <= S_IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      restart    = 1'b0;
      push_req   = 1'b0;
      push_entry = '0;
      if (!en) begin
         state_nxt = S_IDLE;
         restart   = 1'b1;
      end else begin
         case (state)
            S_IDLE: begin
               if (edge_det) begin
                  state_nxt = S_MEASURE;
                  restart   = 1'b1;
               end
            end
            S_MEASURE: begin
               if (edge_det) begin
                  push_req   = 1'b1;
                  push_entry = {1'b0, edge_reg, duration};
                  restart    = 1'b1;
               end else if (tcnt[TIMER_WIDTH]) begin
                  push_req   = 1'b1;
                  push_entry = {1'b1, edge_reg, {TIMER_WIDTH{1'b1}}};
                  state_nxt  = S_IDLE;
                  restart    = 1'b1;
               end
            end
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge sys_rst) begin
      if (sys_rst) begin
         pcnt <= '0;
         tcnt <= '0;
      end else if (restart) begin
         pcnt <= '0;
         tcnt <= '0;
      end else if (state == S_MEASURE) begin
         if (pcnt == pmask) begin
            pcnt <= '0;
            tcnt <= tcnt + 1'b1;
         end else begin
            pcnt <= pcnt + 1'b1;
         end
      end
   end

   // One register stage between the FSM and the FIFO write port
   always_ff @(posedge clk or posedge sys_rst) begin
      if (sys_rst) begin
         push_vld <= 1'b0;
         push_dat <= '0;
      end else begin
         push_vld <= push_req;
         push_dat <= push_entry;
      end
   end

   assign rd.out_valid = (count != '0);
   assign pop          = rd.out_valid & rd.out_ready;
   assign accept       = push_vld & ((count < (AW+1)'(FIFO_DEPTH)) | pop);

   always_ff @(posedge clk) begin
      if (accept) mem[wr_ptr] <= push_dat;
   end

   always_ff @(posedge clk or posedge sys_rst) begin
      if (sys_rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         last_q   <= '0;
         overflow <= 1'b0;
      end else begin
         if (accept) wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            last_q <= mem[rd_ptr];
         end
         count <= count + (AW+1)'(accept) - (AW+1)'(pop);
         if (push_vld & ~accept)  overflow <= 1'b1;
         else if (clr_overflow)   overflow <= 1'b0;
      end
   end

   // An empty FIFO keeps presenting the entry that was popped last
   assign rd.out_data = rd.out_valid ? mem[rd_ptr] : last_q;
   assign busy        = (state == S_MEASURE);

endmodule

// File: tb/tb_pulse_receiver_duration_capture.sv
// Bench for pulse_receiver_duration_capture: timestamp-based reference model, directed scenarios, random segments.
module tb_pulse_receiver_duration_capture;
   localparam int PW    = 16;
   localparam int TW    = 4;
   localparam int DEPTH = 4;
   localparam int PSW   = $clog2(PW + 1);
   localparam int DW    = TW + 2;

   logic           clk = 1'b0;
   logic           sys_rst = 1'b1;
   logic           en = 1'b0;
   logic [PSW-1:0] prescaler = '0;
   logic           sig_in = 1'b0;
   logic           clr_overflow = 1'b0;
   logic           overflow, busy;

   pulse_receiver_duration_capture_if #(.DATA_W(DW)) rx_if ();

   pulse_receiver_duration_capture #(
      .PRESCALER_WIDTH(PW), .TIMER_WIDTH(TW), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .sys_rst(sys_rst), .en(en), .prescaler(prescaler), .sig_in(sig_in),
      .overflow(overflow), .clr_overflow(clr_overflow), .busy(busy), .rd(rx_if)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: timestamps of detected edges, a queue for the FIFO
   logic [DW-1:0] mq[$];
   bit            m_ovf = 0, m_meas = 0, pend = 0;
   logic [DW-1:0] pend_d = '0;
   int            m_n = 0, m_t0 = 0;
   bit            samp[4] = '{default: 1'b0};

   always @(posedge clk or posedge sys_rst) begin
      if (sys_rst) begin
         mq.delete();
         m_ovf = 0; m_meas = 0; pend = 0; m_n = 0; m_t0 = 0;
         samp = '{default: 1'b0};
      end else begin
         bit pop, det, drop;
         int c, d, p;
         m_n++;
         p    = int'(prescaler);
         pop  = (mq.size() > 0) && rx_if.out_ready;
         if (pop) void'(mq.pop_front());
         drop = 0;
         if (pend) begin
            if (mq.size() < DEPTH) mq.push_back(pend_d);
            else drop = 1;
         end
         if (drop) m_ovf = 1;
         else if (clr_overflow) m_ovf = 0;
         pend = 0;
         samp[3] = samp[2]; samp[2] = samp[1]; samp[1] = samp[0]; samp[0] = sig_in;
         det = (samp[2] != samp[3]);
         if (!en) begin
            m_meas = 0;
         end else if (m_meas) begin
            c = m_n - m_t0;
            if (det) begin
               d = ((c - 1) >> p) - 1;
               if (d < 0) d = 0;
               pend = 1; pend_d = {1'b0, samp[3], TW'(d)};
               m_t0 = m_n;
            end else if (((c - 1) >> p) == (1 << TW)) begin
               pend = 1; pend_d = {1'b1, samp[3], {TW{1'b1}}};
               m_meas = 0;
            end
         end else if (det) begin
            m_meas = 1;
            m_t0   = m_n;
         end
      end
   end

   always @(negedge clk) begin
      if (!sys_rst) begin
         chk("out_valid", rx_if.out_valid, 32'(mq.size() > 0));
         if (mq.size() > 0) chk("out_data", rx_if.out_data, mq[0]);
         chk("busy", busy, m_meas);
         chk("overflow", overflow, m_ovf);
      end
   end

   task automatic cyc(int k);
      repeat (k) @(negedge clk);
   endtask

   task automatic tog();
      sig_in = ~sig_in;
   endtask

   task automatic pop_chk(string nm, logic [DW-1:0] exp);
      chk({nm, "_valid"}, rx_if.out_valid, 1);
      chk(nm, rx_if.out_data, exp);
      if (mq.size() > 0) chk({nm, "_model"}, mq[0], exp);
      else begin
         n_cmp++; n_bad++;
         $display("FAIL %s_model: model queue empty, expected %0h", nm, exp);
      end
      rx_if.out_ready = 1'b1;
      cyc(1);
      rx_if.out_ready = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rx_if.out_ready = 1'b0;
      cyc(3);
      sys_rst = 1'b0;
      chk("rst_valid", rx_if.out_valid, 0);
      chk("rst_data", rx_if.out_data, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_busy", busy, 0);

      // T1: p=0, 10-cycle segments
      en = 1'b1; cyc(2);
      tog(); cyc(10); tog(); cyc(10); tog(); cyc(5);
      pop_chk("t1_a", 6'h18);
      pop_chk("t1_b", 6'h08);

      // T3: timeout on a held line
      cyc(20);
      chk("t3_busy", busy, 0);
      pop_chk("t3_to", 6'h3F);
      tog(); cyc(6);
      chk("t3_noentry", rx_if.out_valid, 0);
      chk("t3_busy2", busy, 1);

      // T2: p=2, C=25 -> 5 and C=3 -> clamped 0
      en = 1'b0; cyc(2); prescaler = 2; cyc(1); en = 1'b1; cyc(1);
      tog(); cyc(25); tog(); cyc(3); tog(); cyc(5);
      pop_chk("t2_d5", 6'h15);
      pop_chk("t2_d0", 6'h00);
      en = 1'b0; cyc(2); prescaler = 0; en = 1'b1; cyc(1);

      // T4: overflow, then pop+push on a full FIFO
      tog();
      repeat (4) begin cyc(6); tog(); end
      cyc(6); tog();
      cyc(9);
      chk("t4_valid", rx_if.out_valid, 1);
      chk("t4_ovf", overflow, 1);
      tog(); cyc(3);
      rx_if.out_ready = 1'b1; cyc(1); rx_if.out_ready = 1'b0;
      en = 1'b0;
      clr_overflow = 1'b1; cyc(1); clr_overflow = 1'b0;
      chk("t4_ovf_clr", overflow, 0);
      pop_chk("t4_e1", 6'h14);
      pop_chk("t4_e2", 6'h04);
      pop_chk("t4_e3", 6'h14);
      pop_chk("t4_e4", 6'h17);
      chk("t4_empty", rx_if.out_valid, 0);

      // T5: reset mid-measure with two entries queued
      en = 1'b1; cyc(1);
      tog(); cyc(5); tog(); cyc(5); tog(); cyc(5);
      chk("t5_pre_valid", rx_if.out_valid, 1);
      #2 sys_rst = 1'b1; sig_in = 1'b0;
      #1;
      chk("t5_rst_valid", rx_if.out_valid, 0);
      chk("t5_rst_busy", busy, 0);
      cyc(2); sys_rst = 1'b0;
      cyc(3); tog(); cyc(6);
      chk("t5_first_edge", rx_if.out_valid, 0);
      chk("t5_busy", busy, 1);

      // T6: en=0 mid-segment keeps the queued entry
      tog(); cyc(6);
      en = 1'b0; cyc(2);
      chk("t6_busy", busy, 0);
      pop_chk("t6_keep", 6'h14);
      en = 1'b1; cyc(2);
      tog(); cyc(8);
      chk("t6_first", rx_if.out_valid, 0);
      chk("t6_busy2", busy, 1);
      tog(); cyc(5);
      pop_chk("t6_d6", 6'h16);

      // Random segments against the model
      for (int it = 0; it < 400; it++) begin
         int len;
         if ($urandom_range(0, 19) == 0) begin
            en = 1'b0; cyc(2);
            prescaler = PSW'($urandom_range(0, 2));
            en = 1'b1;
         end
         len = ($urandom_range(0, 7) == 0) ? $urandom_range(15, 80) : $urandom_range(1, 25);
         tog();
         repeat (len) begin
            rx_if.out_ready = 1'($urandom_range(0, 1));
            clr_overflow    = ($urandom_range(0, 15) == 0);
            cyc(1);
         end
      end
      clr_overflow = 1'b0;
      rx_if.out_ready = 1'b1;
      cyc(20);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
